// File: rtl/mem_bridge.sv
// Core data-port to single-beat memory bus bridge with alignment checks and lane steering.
// Latency: request cycle 0, bus_req from cycle 1, rsp_valid one cycle after bus termination (min 2).
// Backpressure: stall holds the core while a request is open; bus waits via bus_ack, bounded by TIMEOUT.
//
// Ports:
//   clk, rst (async, active-low)
//   req_valid/req_we/req_size/req_unsigned/req_addr/req_wdata : core request, held until rsp_valid
//   stall, rsp_valid, rsp_rdata, rsp_err                       : core response side
//   bus_req/bus_we/bus_addr/bus_be/bus_wdata                   : registered bus request
//   bus_ack/bus_rdata/bus_err                                  : bus completion
//
// TIMEOUT is the number of BUS cycles to wait for ack/err; legal range 2..255.

module mem_bridge #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        req_valid,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,

    output logic        stall,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,

    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    input  logic        bus_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Last BUS cycle index before the access is declared timed out.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t      state;
    logic [7:0]  to_cnt;

    // Attributes of the in-flight access needed once the bus answers.
    logic        lat_we;
    logic [1:0]  lat_size;
    logic        lat_unsigned;
    logic [1:0]  lat_off;

    logic        req_legal;
    logic [3:0]  be_nxt;
    logic [31:0] wdata_nxt;
    logic [31:0] rd_shifted;
    logic [31:0] rd_ext;

    // The core is held for the whole access except the response cycle,
    // which is when it is allowed to advance.
    assign stall = req_valid && (state != RESP);

    // Alignment / size legality of the request presented in IDLE.
    always_comb begin
        req_legal = 1'b0;
        case (req_size)
            SZ_BYTE: req_legal = 1'b1;
            SZ_HALF: req_legal = ~req_addr[0];
            SZ_WORD: req_legal = (req_addr[1:0] == 2'b00);
            default: req_legal = 1'b0;
        endcase
    end

    // Byte enables and lane replication so any byte/half lands on every lane
    // it could occupy; the enables pick the real one.
    always_comb begin
        be_nxt    = 4'b1111;
        wdata_nxt = req_wdata;
        case (req_size)
            SZ_BYTE: begin
                be_nxt    = 4'b0001 << req_addr[1:0];
                wdata_nxt = {4{req_wdata[7:0]}};
            end
            SZ_HALF: begin
                be_nxt    = req_addr[1] ? 4'b1100 : 4'b0011;
                wdata_nxt = {2{req_wdata[15:0]}};
            end
            default: begin
                be_nxt    = 4'b1111;
                wdata_nxt = req_wdata;
            end
        endcase
    end

    // Load extraction: bring the addressed byte/half down to bit 0, then extend.
    assign rd_shifted = bus_rdata >> {lat_off, 3'b000};

    always_comb begin
        rd_ext = rd_shifted;
        case (lat_size)
            SZ_BYTE: rd_ext = {{24{~lat_unsigned & rd_shifted[7]}},  rd_shifted[7:0]};
            SZ_HALF: rd_ext = {{16{~lat_unsigned & rd_shifted[15]}}, rd_shifted[15:0]};
            default: rd_ext = rd_shifted;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            to_cnt       <= 8'd0;
            lat_we       <= 1'b0;
            lat_size     <= 2'b00;
            lat_unsigned <= 1'b0;
            lat_off      <= 2'b00;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= 32'd0;
            rsp_err      <= 1'b0;
            bus_req      <= 1'b0;
            bus_we       <= 1'b0;
            bus_addr     <= 32'd0;
            bus_be       <= 4'd0;
            bus_wdata    <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (req_legal) begin
                            state        <= BUS;
                            to_cnt       <= 8'd0;
                            lat_we       <= req_we;
                            lat_size     <= req_size;
                            lat_unsigned <= req_unsigned;
                            lat_off      <= req_addr[1:0];
                            bus_req      <= 1'b1;
                            bus_we       <= req_we;
                            bus_addr     <= {req_addr[31:2], 2'b00};
                            bus_be       <= be_nxt;
                            bus_wdata    <= wdata_nxt;
                        end else begin
                            // Faulting request never touches the bus.
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= 32'd0;
                        end
                    end
                end

                BUS: begin
                    // Priority: bus error, then ack, then timeout. An ack on
                    // the final allowed cycle still completes normally.
                    if (bus_err || bus_ack || (to_cnt == TO_LAST)) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        bus_req   <= 1'b0;
                        bus_we    <= 1'b0;
                        bus_addr  <= 32'd0;
                        bus_be    <= 4'd0;
                        bus_wdata <= 32'd0;
                        if (bus_err) begin
                            rsp_err   <= 1'b1;
                            rsp_rdata <= 32'd0;
                        end else if (bus_ack) begin
                            rsp_err   <= 1'b0;
                            rsp_rdata <= lat_we ? 32'd0 : rd_ext;
                        end else begin
                            rsp_err   <= 1'b1;
                            rsp_rdata <= 32'd0;
                        end
                    end else begin
                        to_cnt <= to_cnt + 8'd1;
                    end
                end

                RESP: begin
                    // Single-cycle strobe; the core's request is ignored here
                    // because it is still showing the one just answered.
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= 32'd0;
                end

                default: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= 32'd0;
                    bus_req   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bridge.sv
// Self-checking bench for mem_bridge: directed cases plus a randomized sweep, scoreboarded responses.
// Latency: each access task drives one request and plays the bus for a chosen number of cycles.
// Backpressure: the bench holds req_valid until the response cycle, as the core would.

module tb_mem_bridge;

    localparam int TIMEOUT = 16;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        bus_err;

    mem_bridge #(.TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .stall        (stall),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .bus_req      (bus_req),
        .bus_we       (bus_we),
        .bus_addr     (bus_addr),
        .bus_be       (bus_be),
        .bus_wdata    (bus_wdata),
        .bus_ack      (bus_ack),
        .bus_rdata    (bus_rdata),
        .bus_err      (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    rsp_t exp_q[$];

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int rsp_cnt = 0;
    int last_rsp_cyc = 0;
    int prev_rsp_cyc = 0;
    logic prev_rsp = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    endtask

    always @(posedge clk) cyc++;

    // Response monitor: pops the scoreboard on every strobe and checks the
    // strobe lasts one cycle with data/err returning to zero afterwards.
    always @(negedge clk) begin
        if (rst && prev_rsp) begin
            chk("rsp_one_cycle", rsp_valid, 0);
            chk("rsp_idle_clear", {rsp_err, rsp_rdata}, 0);
        end
        if (rsp_valid) begin
            rsp_cnt++;
            prev_rsp_cyc = last_rsp_cyc;
            last_rsp_cyc = cyc;
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", exp_q.size(), 1);
            end else begin
                rsp_t e;
                e = exp_q.pop_front();
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("rsp_err", rsp_err, e.err);
            end
        end
        prev_rsp = rst ? rsp_valid : 1'b0;
    end

    // One core access. Called just after a rising edge. kind: 0 ack, 1 err,
    // 2 ack+err together, 3 never answer. term_k is the BUS cycle (1-based)
    // on which the terminator is driven.
    task automatic access(input string tag, input logic we, input logic [1:0] size,
                          input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rword, input int term_k, input int kind,
                          input int exp_nbus, input logic [31:0] exp_rdata, input logic exp_err,
                          input logic [3:0] exp_be, input logic [31:0] exp_wd);
        int   nbus;
        int   k;
        logic ok;
        exp_q.push_back('{exp_rdata, exp_err});
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        #2;
        chk({tag, ".stall_req"}, stall, 1);
        chk({tag, ".no_bus_c0"}, bus_req, 0);
        nbus = 0;
        ok   = 1'b1;
        k    = 1;
        @(posedge clk); #1;
        while (k < 64) begin
            bus_ack   = (kind == 0 || kind == 2) && (k == term_k);
            bus_err   = (kind == 1 || kind == 2) && (k == term_k);
            bus_rdata = (k == term_k) ? rword : $urandom;
            @(negedge clk);
            if (!bus_req) break;
            nbus++;
            if (bus_we !== we || bus_addr !== {addr[31:2], 2'b00} || bus_be !== exp_be ||
                (we && bus_wdata !== exp_wd) || stall !== 1'b1) ok = 1'b0;
            @(posedge clk); #1;
            k++;
        end
        bus_ack = 1'b0;
        bus_err = 1'b0;
        chk({tag, ".bus_cycles"}, nbus, exp_nbus);
        if (exp_nbus > 0) chk({tag, ".bus_fields"}, ok, 1);
        chk({tag, ".rsp_strobe"}, rsp_valid, 1);
        chk({tag, ".stall_resp"}, stall, 0);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    initial begin
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rword;
        logic [31:0] sh;
        logic [31:0] ext;
        logic [3:0]  be;
        logic [31:0] wd;
        logic        legal;
        int          tk;
        int          kind;
        int          base;

        rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
        bus_ack = 1'b0; bus_rdata = 32'd0; bus_err = 1'b0;

        // Reset state, stall tracking req_valid during reset.
        #3;
        chk("rst.outputs", {rsp_valid, rsp_err, rsp_rdata, bus_req, bus_we, bus_addr, bus_be, bus_wdata}, 0);
        chk("rst.stall_lo", stall, 0);
        req_valid = 1'b1;
        #1;
        chk("rst.stall_hi", stall, 1);
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // Signed byte load from top lane.
        access("ldb_s", 0, 2'b00, 0, 32'h103, 0, 32'h80FF_1234, 1, 0, 1, 32'hFFFF_FF80, 0, 4'b1000, 0);
        // Half store in upper lanes.
        access("sth", 1, 2'b01, 0, 32'h22, 32'hDEAD_BEEF, 32'h0, 1, 0, 1, 32'h0, 0, 4'b1100, 32'hBEEF_BEEF);
        // Misaligned word load: no bus activity, immediate error.
        access("ldw_mis", 0, 2'b10, 0, 32'h6, 0, 0, 0, 3, 0, 32'h0, 1, 4'b0000, 0);
        // Illegal size.
        access("ill_sz", 1, 2'b11, 0, 32'h8, 32'h1, 0, 0, 3, 0, 32'h0, 1, 4'b0000, 0);
        // Misaligned half.
        access("ldh_mis", 0, 2'b01, 1, 32'h41, 0, 0, 0, 3, 0, 32'h0, 1, 4'b0000, 0);
        // Unsigned half load from upper lanes, signed half from lower lanes.
        access("ldh_u", 0, 2'b01, 1, 32'h1002, 0, 32'h9ABC_5678, 2, 0, 2, 32'h0000_9ABC, 0, 4'b1100, 0);
        access("ldh_s", 0, 2'b01, 0, 32'h1000, 0, 32'h1234_8001, 1, 0, 1, 32'hFFFF_8001, 0, 4'b0011, 0);
        access("ldb_u", 0, 2'b00, 1, 32'h201, 0, 32'h00C3_F100, 1, 0, 1, 32'h0000_00F1, 0, 4'b0010, 0);
        access("stb", 1, 2'b00, 0, 32'h303, 32'h1234_56A5, 0, 1, 0, 1, 32'h0, 0, 4'b1000, 32'hA5A5_A5A5);
        access("stw", 1, 2'b10, 0, 32'hFFFF_FFFC, 32'h0BAD_F00D, 0, 3, 0, 3, 32'h0, 0, 4'b1111, 32'h0BAD_F00D);
        access("ldw", 0, 2'b10, 0, 32'h400, 0, 32'hCAFE_0001, 1, 0, 1, 32'hCAFE_0001, 0, 4'b1111, 0);
        // Bus error on a store.
        access("st_berr", 1, 2'b10, 0, 32'h500, 32'h5, 0, 2, 1, 2, 32'h0, 1, 4'b1111, 32'h5);
        // Timeout, ack on the last allowed cycle, ack+err together.
        access("tmo", 0, 2'b10, 0, 32'h40, 0, 0, 0, 3, TIMEOUT, 32'h0, 1, 4'b1111, 0);
        access("ack_last", 0, 2'b10, 0, 32'h48, 0, 32'h7777_0000, TIMEOUT, 0, TIMEOUT, 32'h7777_0000, 0, 4'b1111, 0);
        access("ack_err", 0, 2'b10, 0, 32'h44, 0, 32'h1234_5678, 2, 2, 2, 32'h0, 1, 4'b1111, 0);

        // Back-to-back loads, three BUS cycles each: responses five cycles apart.
        access("b2b_a", 0, 2'b10, 0, 32'h600, 0, 32'h1111_1111, 3, 0, 3, 32'h1111_1111, 0, 4'b1111, 0);
        access("b2b_b", 0, 2'b10, 0, 32'h604, 0, 32'h2222_2222, 3, 0, 3, 32'h2222_2222, 0, 4'b1111, 0);
        chk("b2b.gap", last_rsp_cyc - prev_rsp_cyc, 5);

        // Stray ack/err while idle must do nothing.
        base = rsp_cnt;
        bus_ack = 1'b1; bus_err = 1'b1;
        repeat (2) @(posedge clk);
        #1 bus_ack = 1'b0; bus_err = 1'b0;
        @(negedge clk);
        chk("idle_ack.no_rsp", rsp_cnt, base);
        chk("idle_ack.no_bus", bus_req, 0);
        @(posedge clk); #1;

        // Reset in BUS cycle 2 abandons the access.
        base = rsp_cnt;
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'h800;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_mid.bus_before", bus_req, 1);
        rst = 1'b0;
        #1;
        chk("rst_mid.bus_drop", bus_req, 0);
        chk("rst_mid.outputs", {rsp_valid, rsp_err, rsp_rdata, bus_be, bus_addr}, 0);
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        // First edge after release accepts the next request.
        access("post_rst", 0, 2'b00, 0, 32'h902, 0, 32'h0055_0000, 1, 0, 1, 32'h0000_0055, 0, 4'b0100, 0);
        chk("rst_mid.one_rsp", rsp_cnt, base + 1);

        // Randomized sweep against a reference model.
        for (int i = 0; i < 24; i++) begin
            we    = 1'($urandom_range(0, 1));
            size  = 2'($urandom_range(0, 3));
            uns   = 1'($urandom_range(0, 1));
            addr  = $urandom;
            wdata = $urandom;
            rword = $urandom;
            tk    = $urandom_range(1, 4);
            kind  = ($urandom_range(0, 4) == 0) ? 1 : 0;
            legal = (size == 2'b00) || (size == 2'b01 && !addr[0]) ||
                    (size == 2'b10 && addr[1:0] == 2'b00);
            sh    = rword >> (8 * addr[1:0]);
            case (size)
                2'b00: begin
                    be  = 4'b0001 << addr[1:0];
                    wd  = {wdata[7:0], wdata[7:0], wdata[7:0], wdata[7:0]};
                    ext = uns ? {24'd0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
                end
                2'b01: begin
                    be  = addr[1] ? 4'b1100 : 4'b0011;
                    wd  = {wdata[15:0], wdata[15:0]};
                    ext = uns ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
                end
                default: begin
                    be  = 4'b1111;
                    wd  = wdata;
                    ext = sh;
                end
            endcase
            if (!legal)
                access("rnd_ill", we, size, uns, addr, wdata, rword, 0, 3, 0, 32'h0, 1, be, wd);
            else
                access("rnd", we, size, uns, addr, wdata, rword, tk, kind, tk,
                       (we || kind == 1) ? 32'h0 : ext, (kind == 1), be, wd);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("sb.drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1);
    end

endmodule

// File: doc/mem_bridge.md
MEM_BRIDGE -- requirements
Module: mem_bridge

Interface
REQ-001 Parameter TIMEOUT, default 16: max cycles in BUS state awaiting bus_ack/bus_err; legal range 2..255.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  1  core data-port access request, held by core until rsp_valid.
REQ-005 req_we  input  1  1 = store, 0 = load.
REQ-006 req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-007 req_unsigned  input  1  load zero-extend (1) vs sign-extend (0).
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data, LSB-justified.
REQ-010 stall  output  1  core must hold PC and request while high.
REQ-011 rsp_valid  output  1  one-cycle response strobe.
REQ-012 rsp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-013 rsp_err  output  1  access fault (misaligned, illegal size, bus error, timeout); valid with rsp_valid.
REQ-014 bus_req  output  1  bus request, registered.
REQ-015 bus_we  output  1  bus write, registered.
REQ-016 bus_addr  output  32  word address, {req_addr[31:2],2'b00}, registered.
REQ-017 bus_be  output  4  byte enables, registered.
REQ-018 bus_wdata  output  32  lane-replicated store data, registered.
REQ-019 bus_ack  input  1  bus completes transfer this cycle.
REQ-020 bus_rdata  input  32  read word, valid with bus_ack.
REQ-021 bus_err  input  1  bus fault this cycle, terminates transfer.

Function
REQ-022 FSM states: IDLE, BUS, RESP.
REQ-023 IDLE: req_valid and aligned legal access -> BUS, latch we/size/unsigned/addr[1:0], drive bus_* registers; req_valid and misaligned/illegal -> RESP with err, no bus_req ever raised.
REQ-024 Misaligned: half with addr[0]=1; word with addr[1:0]!=0; size 11 always illegal.
REQ-025 BUS: bus_req=1 and bus_* stable every cycle until termination.
REQ-026 BUS termination priority: bus_err > bus_ack > timeout; any termination -> RESP next cycle, bus_req low in RESP.
REQ-027 Timeout: 8-bit counter cleared on IDLE->BUS, increments each BUS cycle; count==TIMEOUT-1 without ack/err -> RESP with err.
REQ-028 RESP: rsp_valid=1 exactly one cycle, then IDLE; req_valid ignored in RESP.
REQ-029 stall = req_valid && (state != RESP); core advances at end of RESP cycle.
REQ-030 Min latency: request cycle 0, bus_req cycle 1, ack cycle 1, rsp_valid cycle 2; each added wait cycle adds one.
REQ-031 Byte enables: byte 4'b0001<<addr[1:0]; half 4'b0011 (addr[1]=0) or 4'b1100; word 4'b1111.
REQ-032 Write lanes: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
REQ-033 Load extract: shift bus_rdata right by 8*addr[1:0], take low 8/16/32 bits, extend per req_unsigned; result registered on ack into rsp_rdata.
REQ-034 rsp_rdata = 0 and rsp_err held only during RESP; both 0 outside RESP.
REQ-035 bus_ack/bus_err outside BUS are ignored.

Reset
REQ-036 rst low asynchronously forces IDLE, counter 0, all outputs 0 (stall follows req_valid per REQ-029).
REQ-037 Reset mid-BUS abandons transaction; bus_req drops immediately, no rsp_valid generated.
REQ-038 First request accepted on first rising edge after rst deasserts.

Verification
REQ-039 Load byte addr 0x103, unsigned=0, bus_rdata 0x80FF_1234 ack in 1 cycle -> bus_be 1000, rsp_rdata 0xFFFF_FF80, rsp_valid cycle 2, rsp_err 0.
REQ-040 Store half addr 0x22, wdata 0xDEAD_BEEF -> bus_addr 0x20, bus_be 1100, bus_wdata 0xBEEF_BEEF, bus_we 1, rsp_rdata 0.
REQ-041 Load word addr 0x6 -> no bus_req, rsp_valid+rsp_err next cycle, stall low that cycle.
REQ-042 TIMEOUT=16, bus_ack never -> bus_req high 16 cycles, rsp_err 1; separately ack+err same cycle -> rsp_err 1.
REQ-043 Two back-to-back loads with 3-cycle bus wait each -> responses 5 cycles apart, stall low only in RESP cycles.
REQ-044 rst low during BUS cycle 2 -> bus_req 0 immediately, no rsp_valid, next request after release completes normally.
